// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit_pkg
// Purpose : Shared constants and types for the load/store alignment stage.
//           Holds the access-size encodings, the FSM state type, the data word
//           width and a misalignment helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  // Size 2'b11 is reserved and handled as a word, so it falls in the default.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit_if
// Purpose : Core-side request/response bundle of the load/store alignment
//           stage.
// Ports   : req_valid, req_we, req_size, req_signed, req_addr, req_wdata
//           (core -> unit); stall, load_data, misalign (unit -> core).
//           modport master = core side, modport slave = alignment unit.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  stall;
  logic [31:0]           load_data;
  logic                  misalign;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  stall, load_data, misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output stall, load_data, misalign
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_lane_mux.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_mux
// Purpose : Combinational byte/halfword lane steering shared by the load and
//           store paths: extracts and extends a load lane, and merges store
//           data into a read word for read-modify-write.
// Ports   : size, sign_ext, lane (addr[1:0]), rdata, wdata -> load_word,
//           merged_word.
// Params  : BIG_ENDIAN - 0: byte 0 in [7:0]; 1: byte 0 in [31:24].
// Revision: 1.0 - initial release
// ============================================================================
module mem_lane_mux
  import mem_access_unit_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_word,
  output logic [WORD_W-1:0] merged_word
);

  localparam logic BE = (BIG_ENDIAN != 0);

  logic [4:0]        shift;
  logic [WORD_W-1:0] lane_mask;
  logic [WORD_W-1:0] shifted;

  // Bit offset of the addressed lane. Big-endian mirrors the lane index,
  // which for a 2-bit (or 1-bit) index is simply its bitwise inverse.
  always_comb begin
    shift     = 5'd0;
    lane_mask = '1;
    case (size)
      SZ_BYTE: begin
        shift     = BE ? {~lane, 3'b000} : {lane, 3'b000};
        lane_mask = 32'h0000_00FF;
      end
      SZ_HALF: begin
        // addr[0] is deliberately ignored: halves are forced to alignment.
        shift     = BE ? {~lane[1], 4'b0000} : {lane[1], 4'b0000};
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        shift     = 5'd0;
        lane_mask = '1;
      end
    endcase
  end

  assign shifted = rdata >> shift;

  always_comb begin
    load_word = rdata;
    case (size)
      SZ_BYTE: load_word = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_word = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_word = rdata;
    endcase
  end

  // For word sizes the mask is all ones with zero shift, giving wdata.
  assign merged_word = (rdata & ~(lane_mask << shift)) |
                       ((wdata & lane_mask) << shift);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Purpose : Load/store alignment stage in front of a word-only data memory.
//           Loads and word stores complete in one cycle; byte/half stores run
//           a two-cycle read-modify-write and stall the core for the read.
// Ports   : clk, rst_n (async, active-low)
//           core  : mem_access_unit_if.slave (req_*, stall, load_data,
//                   misalign)
//           dm_addr, dm_we, dm_wdata (out), dm_rdata (in) - DataMem side.
// Params  : ADDR_WIDTH (byte address width), BIG_ENDIAN (lane order).
// Config  : MEM_MISALIGN_TRAP_EN - when defined, misaligned requests raise
//           misalign and are suppressed; when undefined the low address bits
//           are forced to alignment and misalign is tied low.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_unit_if.slave      core,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic                  dm_we,
  output logic [WORD_W-1:0]     dm_wdata,
  input  logic [WORD_W-1:0]     dm_rdata
);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [WORD_W-1:0]     rmw_word;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  sub_word;
  logic                  bad_align;
  logic                  rmw_start;
  logic [WORD_W-1:0]     load_word;
  logic [WORD_W-1:0]     merged_word;

  assign word_addr = {core.req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign sub_word  = (core.req_size == SZ_BYTE) || (core.req_size == SZ_HALF);

`ifdef MEM_MISALIGN_TRAP_EN
  assign bad_align = core.req_valid &&
                     is_misaligned(core.req_size, core.req_addr[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  assign rmw_start = (state == ST_IDLE) && core.req_valid && core.req_we &&
                     sub_word && !bad_align;

  mem_lane_mux #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_mux (
    .size        (core.req_size),
    .sign_ext    (core.req_signed),
    .lane        (core.req_addr[1:0]),
    .rdata       (dm_rdata),
    .wdata       (core.req_wdata),
    .load_word   (load_word),
    .merged_word (merged_word)
  );

  // The merged word is captured from the read issued during the stall
  // cycle; RMW_WR then writes it back without looking at req_* again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rmw_addr <= '0;
      rmw_word <= '0;
    end else begin
      state <= next_state;
      if (rmw_start) begin
        rmw_addr <= word_addr;
        rmw_word <= merged_word;
      end
    end
  end

  always_comb begin
    next_state     = state;
    dm_addr        = '0;
    dm_we          = 1'b0;
    dm_wdata       = '0;
    core.stall     = 1'b0;
    core.load_data = '0;
    core.misalign  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (core.req_valid) begin
          dm_addr       = word_addr;
          core.misalign = bad_align;
          if (bad_align) begin
            // Trapped access: no write, no RMW, load returns zero.
            next_state = ST_IDLE;
          end else if (!core.req_we) begin
            core.load_data = load_word;
          end else if (sub_word) begin
            core.stall = 1'b1;
            next_state = ST_RMW_WR;
          end else begin
            dm_we    = 1'b1;
            dm_wdata = core.req_wdata;
          end
        end
      end
      ST_RMW_WR: begin
        dm_addr    = rmw_addr;
        dm_we      = 1'b1;
        dm_wdata   = rmw_word;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_unit
// Purpose : Self-checking bench for mem_access_unit with a 16-word memory
//           model. Table-driven load vectors plus hand-written sequences for
//           stores, read-modify-write, back-to-back RMW and reset mid-RMW.
// Config  : MEM_MISALIGN_TRAP_EN selects the misalignment expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        mem_clr = 1'b1;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [31:0] mem [0:15];

  int checks   = 0;
  int failures = 0;

  mem_access_unit_if #(.ADDR_WIDTH(32)) core_if ();

  mem_access_unit #(
    .ADDR_WIDTH (32),
    .BIG_ENDIAN (0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .core     (core_if),
    .dm_addr  (dm_addr),
    .dm_we    (dm_we),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr[5:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (dm_we) begin
      mem[dm_addr[5:2]] <= dm_wdata;
    end
  end

  typedef struct {
    string       name;
    logic        valid;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] exp_load;
    logic        exp_mis;
  } load_vec_t;

  load_vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    core_if.req_valid  = v;
    core_if.req_we     = we;
    core_if.req_size   = sz;
    core_if.req_signed = sg;
    core_if.req_addr   = a;
    core_if.req_wdata  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle word store used to (re)establish the reference word.
  task automatic store_word(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, SZ_WORD, 1'b0, a, d);
    #2;
    chk("sw_we", {31'd0, dm_we}, 32'd1);
    chk("sw_wdata", dm_wdata, d);
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vecs[0]  = '{"lb_s_11",  1'b1, SZ_BYTE, 1'b1, 32'h11, 32'hFFFF_FFAA, 1'b0};
    vecs[1]  = '{"lbu_11",   1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_00AA, 1'b0};
    vecs[2]  = '{"lh_s_12",  1'b1, SZ_HALF, 1'b1, 32'h12, 32'hFFFF_8899, 1'b0};
    vecs[3]  = '{"lhu_12",   1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000_8899, 1'b0};
    vecs[4]  = '{"lw_10",    1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8899_AABB, 1'b0};
    vecs[5]  = '{"lb_s_10",  1'b1, SZ_BYTE, 1'b1, 32'h10, 32'hFFFF_FFBB, 1'b0};
    vecs[6]  = '{"lb_s_13",  1'b1, SZ_BYTE, 1'b1, 32'h13, 32'hFFFF_FF88, 1'b0};
    vecs[7]  = '{"lbu_12",   1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h0000_0099, 1'b0};
    vecs[8]  = '{"lh_s_10",  1'b1, SZ_HALF, 1'b1, 32'h10, 32'hFFFF_AABB, 1'b0};
    vecs[9]  = '{"lrsv_10",  1'b1, 2'b11,   1'b1, 32'h10, 32'h8899_AABB, 1'b0};
    vecs[10] = '{"idle",     1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0000_0000, 1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[11] = '{"lh_s_13",  1'b1, SZ_HALF, 1'b1, 32'h13, 32'h0000_0000, 1'b1};
    vecs[12] = '{"lw_11",    1'b1, SZ_WORD, 1'b0, 32'h11, 32'h0000_0000, 1'b1};
`else
    vecs[11] = '{"lh_s_13",  1'b1, SZ_HALF, 1'b1, 32'h13, 32'hFFFF_8899, 1'b0};
    vecs[12] = '{"lw_11",    1'b1, SZ_WORD, 1'b0, 32'h11, 32'h8899_AABB, 1'b0};
`endif

    // Reset state
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    #3;
    chk("rst_stall",    {31'd0, core_if.stall},    32'd0);
    chk("rst_dm_we",    {31'd0, dm_we},            32'd0);
    chk("rst_dm_wdata", dm_wdata,                  32'd0);
    chk("rst_dm_addr",  dm_addr,                   32'd0);
    chk("rst_misalign", {31'd0, core_if.misalign}, 32'd0);
    tick();
    tick();
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    tick();

    store_word(32'h10, 32'h8899_AABB);

    // Table-driven loads
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, 1'b0, vecs[i].size, vecs[i].sgn, vecs[i].addr, 32'h0);
      #2;
      chk({vecs[i].name, "_data"}, core_if.load_data, vecs[i].exp_load);
      chk({vecs[i].name, "_stall"}, {31'd0, core_if.stall}, 32'd0);
      chk({vecs[i].name, "_we"}, {31'd0, dm_we}, 32'd0);
      chk({vecs[i].name, "_mis"}, {31'd0, core_if.misalign},
          {31'd0, vecs[i].exp_mis});
      chk({vecs[i].name, "_addr"}, dm_addr,
          vecs[i].valid ? {vecs[i].addr[31:2], 2'b00} : 32'h0);
      tick();
    end

    // SB 0x13: read cycle with stall, then write with valid dropped
    drive(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h1122_3344);
    #2;
    chk("sb_c0_stall", {31'd0, core_if.stall}, 32'd1);
    chk("sb_c0_we",    {31'd0, dm_we},         32'd0);
    chk("sb_c0_addr",  dm_addr,                32'h10);
    tick();
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    #2;
    chk("sb_c1_we",    {31'd0, dm_we},         32'd1);
    chk("sb_c1_addr",  dm_addr,                32'h10);
    chk("sb_c1_wdata", dm_wdata,               32'h4499_AABB);
    chk("sb_c1_stall", {31'd0, core_if.stall}, 32'd0);
    tick();
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #2;
    chk("sb_readback", core_if.load_data, 32'h4499_AABB);
    tick();
    store_word(32'h10, 32'h8899_AABB);

    // SH 0x10 then SB 0x10 back-to-back: stall 1,0,1,0
    drive(1'b1, 1'b1, SZ_HALF, 1'b0, 32'h10, 32'h0000_CAFE);
    #2;
    chk("b2b_c0_stall", {31'd0, core_if.stall}, 32'd1);
    tick();
    #2;
    chk("b2b_c1_stall", {31'd0, core_if.stall}, 32'd0);
    chk("b2b_c1_wdata", dm_wdata,               32'h8899_CAFE);
    tick();
    drive(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h0000_0001);
    #2;
    chk("b2b_c2_stall", {31'd0, core_if.stall}, 32'd1);
    chk("b2b_c2_we",    {31'd0, dm_we},         32'd0);
    tick();
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    #2;
    chk("b2b_c3_stall", {31'd0, core_if.stall}, 32'd0);
    chk("b2b_c3_we",    {31'd0, dm_we},         32'd1);
    chk("b2b_c3_wdata", dm_wdata,               32'h8899_CA01);
    tick();
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #2;
    chk("b2b_readback", core_if.load_data, 32'h8899_CA01);
    tick();
    store_word(32'h10, 32'h8899_AABB);

    // Reset asserted while in RMW_WR: write dropped asynchronously
    drive(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h0000_0055);
    tick();
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    #2;
    chk("rstrmw_pre_we", {31'd0, dm_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstrmw_we",    {31'd0, dm_we},         32'd0);
    chk("rstrmw_stall", {31'd0, core_if.stall}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #2;
    chk("rstrmw_word",  core_if.load_data,      32'h8899_AABB);
    chk("rstrmw_idle",  {31'd0, core_if.stall}, 32'd0);
    tick();

    // Misaligned word store
    drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h12, 32'hDEAD_BEEF);
    #2;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("msw_mis",   {31'd0, core_if.misalign}, 32'd1);
    chk("msw_we",    {31'd0, dm_we},            32'd0);
    chk("msw_stall", {31'd0, core_if.stall},    32'd0);
    tick();
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #2;
    chk("msw_word",  core_if.load_data,         32'h8899_AABB);
`else
    chk("msw_mis",   {31'd0, core_if.misalign}, 32'd0);
    chk("msw_we",    {31'd0, dm_we},            32'd1);
    chk("msw_addr",  dm_addr,                   32'h10);
    chk("msw_wdata", dm_wdata,                  32'hDEAD_BEEF);
    tick();
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #2;
    chk("msw_word",  core_if.load_data,         32'hDEAD_BEEF);
`endif
    tick();
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
